// File: rtl/i2c_master_pkg.sv
// Shared command codes, FSM states and bit-timing constants for the I2C byte master.
package i2c_master_pkg;

    typedef enum logic [2:0] {
        CMD_START    = 3'd0,
        CMD_STOP     = 3'd1,
        CMD_WRITE    = 3'd2,
        CMD_READ_ACK = 3'd3,
        CMD_READ_NAK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_BIT,
        ST_ACKBIT,
        ST_DONE
    } i2c_state_t;

    localparam int unsigned QUARTERS_PER_BIT = 4;

    function automatic logic is_byte_cmd(input logic [2:0] code);
        return (code == CMD_WRITE) || (code == CMD_READ_ACK) || (code == CMD_READ_NAK);
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit prescaler: tick on the last count of each quarter, 2-bit quarter index,
// and a hold input that freezes the count at 0 while a slave stretches SCL.
module i2c_quarter_timer
    import i2c_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       hold,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);

    logic [15:0] count;

    assign tick = enable && !hold && (count == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            quarter <= '0;
        end else if (clear) begin
            count   <= '0;
            quarter <= '0;
        end else if (enable) begin
            if (hold) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                count   <= '0;
                quarter <= quarter + 2'd1;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: turns START/STOP/WRITE/READ commands into open-drain
// SCL/SDA waveforms, four quarters per bit, with slave clock stretching.
module i2c_byte_master
    import i2c_master_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned I2C_DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2:0]                cmd_i,
    input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
    output logic                      done_o,
    output logic [I2C_DATA_WIDTH-1:0] rdata_o,
    output logic                      ack_o,
    output logic                      busy_o,
    input  logic                      scl_i,
    output logic                      scl_o,
    input  logic                      sda_i,
    output logic                      sda_o
);

    localparam int unsigned BIT_CNT_W = (I2C_DATA_WIDTH > 1) ? $clog2(I2C_DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(I2C_DATA_WIDTH - 1);
    localparam logic [1:0] LAST_Q = 2'(QUARTERS_PER_BIT - 1);

    i2c_state_t state, state_next;

    logic [2:0]                cmd_q;
    logic [I2C_DATA_WIDTH-1:0] shreg;
    logic                      sample_q;
    logic [BIT_CNT_W-1:0]      bit_cnt;

    logic       accept;
    logic       active;
    logic       hold;
    logic       tick;
    logic [1:0] quarter;
    logic       end_of_bit;
    logic       bus_owned;

    assign accept     = cmd_valid_i && cmd_ready_o;
    assign active     = (state == ST_START) || (state == ST_STOP) ||
                        (state == ST_BIT)   || (state == ST_ACKBIT);
    assign hold       = active && (quarter == 2'd1) && !scl_i;
    assign end_of_bit = tick && (quarter == LAST_Q);

    // Ownership as it will be once the finishing command has taken effect, so SCL
    // is neither released after a START nor pulled again after a STOP.
    assign bus_owned = ((state == ST_DONE) && (cmd_q == CMD_START)) ||
                       (busy_o && !((state == ST_DONE) && (cmd_q == CMD_STOP)));

    i2c_quarter_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (accept),
        .enable (active),
        .hold   (hold),
        .tick   (tick),
        .quarter(quarter)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready_o = 1'b0;
        scl_o       = 1'b1;
        sda_o       = 1'b1;
        case (state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                scl_o       = !bus_owned;
                if (cmd_valid_i) begin
                    if (cmd_i == CMD_START) begin
                        state_next = ST_START;
                    end else if (cmd_i == CMD_STOP) begin
                        state_next = ST_STOP;
                    end else if (is_byte_cmd(cmd_i)) begin
                        state_next = ST_BIT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_START: begin
                case (quarter)
                    2'd0:    scl_o = !busy_o;
                    2'd1:    ;
                    2'd2:    sda_o = 1'b0;
                    default: begin
                        scl_o = 1'b0;
                        sda_o = 1'b0;
                    end
                endcase
                if (end_of_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_STOP: begin
                case (quarter)
                    2'd0: begin
                        scl_o = 1'b0;
                        sda_o = 1'b0;
                    end
                    2'd1:    sda_o = 1'b0;
                    default: ;
                endcase
                if (end_of_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_BIT: begin
                scl_o = (quarter == 2'd1) || (quarter == 2'd2);
                sda_o = (cmd_q == CMD_WRITE) ? shreg[I2C_DATA_WIDTH-1] : 1'b1;
                if (end_of_bit && (bit_cnt == LAST_BIT)) begin
                    state_next = ST_ACKBIT;
                end
            end
            ST_ACKBIT: begin
                scl_o = (quarter == 2'd1) || (quarter == 2'd2);
                sda_o = (cmd_q != CMD_READ_ACK);
                if (end_of_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                scl_o      = !bus_owned;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One shift register serves both directions: it transmits from the MSB and
    // refills from the LSB with whatever the line carried during that bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q    <= '0;
            shreg    <= '0;
            sample_q <= 1'b0;
            bit_cnt  <= '0;
            done_o   <= 1'b0;
            rdata_o  <= '0;
            ack_o    <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            done_o <= (state == ST_DONE);
            if (accept) begin
                cmd_q   <= cmd_i;
                shreg   <= wdata_i;
                bit_cnt <= '0;
            end
            if (tick && (quarter == 2'd2)) begin
                sample_q <= sda_i;
            end
            if ((state == ST_BIT) && end_of_bit) begin
                shreg   <= (shreg << 1) | I2C_DATA_WIDTH'(sample_q);
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
            end
            if (state == ST_DONE) begin
                case (cmd_q)
                    CMD_START:    busy_o  <= 1'b1;
                    CMD_STOP:     busy_o  <= 1'b0;
                    CMD_WRITE:    ack_o   <= sample_q;
                    CMD_READ_ACK,
                    CMD_READ_NAK: rdata_o <= shreg;
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: a behavioural slave and bus monitor
// compare bits, START/STOP conditions, latency and result registers against a model.
module tb_i2c_byte_master;

    localparam int CD      = 4;
    localparam int STRETCH = 50;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic [7:0] wdata;
    logic       done;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;
    logic       scl_o;
    logic       sda_o;
    logic       slave_scl;
    logic       slave_sda;
    logic       scl_line;
    logic       sda_line;

    int n_cmp = 0;
    int n_err = 0;

    logic       m_busy;
    logic       m_ack;
    logic [7:0] m_rdata;

    assign scl_line = scl_o & slave_scl;
    assign sda_line = sda_o & slave_sda;

    i2c_byte_master #(
        .CLK_DIV       (CD),
        .I2C_DATA_WIDTH(8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_i      (cmd),
        .wdata_i    (wdata),
        .done_o     (done),
        .rdata_o    (rdata),
        .ack_o      (ack),
        .busy_o     (busy),
        .scl_i      (scl_line),
        .scl_o      (scl_o),
        .sda_i      (sda_line),
        .sda_o      (sda_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and act as slave/monitor until done_o (or abort on reset).
    task automatic run_cmd(input logic [2:0] c, input logic [7:0] wd, input logic [7:0] sb,
                           input logic sack, input int stretch_at, input int rst_at);
        int         lat_exp, rises, starts, stops, toggles, stretch_left, budget, done_cyc;
        bit         stretched, got_done, aborted, released, is_read, is_byte, is_bus;
        bit         rdy_at_done;
        logic       sl, sd, prev_scl, prev_sda, prev_scl_o, prev_sda_o, first_scl_o, busy_before;
        logic [8:0] bits_seen, bits_exp;
        logic [7:0] rdata_at_done;
        logic       ack_at_done, busy_at_done;

        is_read = (c == 3'd3) || (c == 3'd4);
        is_byte = (c == 3'd2) || is_read;
        is_bus  = (c <= 3'd4);
        lat_exp = is_byte ? 36 * CD + 1 : (is_bus ? 4 * CD + 1 : 1);
        if (stretch_at >= 0) lat_exp += STRETCH;
        bits_exp    = (c == 3'd2) ? {wd, sack} : {sb, (c == 3'd4)};
        busy_before = m_busy;
        rises = 0; starts = 0; stops = 0; toggles = 0; stretch_left = 0;
        stretched = 0; got_done = 0; aborted = 0; done_cyc = -1;
        bits_seen = '0; rdy_at_done = 0; first_scl_o = 1'bx;
        rdata_at_done = 'x; ack_at_done = 1'bx; busy_at_done = 1'bx;

        slave_scl = 1'b1;
        slave_sda = is_read ? sb[7] : 1'b1;
        @(negedge clk);
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd       = c;
        wdata     = wd;
        prev_scl   = scl_o & slave_scl;
        prev_sda   = sda_o & slave_sda;
        prev_scl_o = scl_o;
        prev_sda_o = sda_o;
        @(posedge clk);
        budget = lat_exp + 100;
        for (int cyc = 0; cyc <= budget && !got_done && !aborted; cyc++) begin
            @(negedge clk);
            released = 0;
            if (cyc == 0) begin
                cmd_valid = 1'b0;
                wdata     = 8'($urandom);
                check("ready_after_accept", cmd_ready, 0);
                first_scl_o = scl_o;
            end
            sl = scl_o & slave_scl;
            sd = sda_o & slave_sda;
            if (scl_o !== prev_scl_o) toggles++;
            if (sda_o !== prev_sda_o) toggles++;
            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) begin
                    slave_scl = 1'b1;
                    released  = 1;
                end
            end else if (sl && !prev_scl) begin
                if (stretch_at >= 0 && !stretched && rises == stretch_at) begin
                    stretched    = 1;
                    slave_scl    = 1'b0;
                    stretch_left = STRETCH;
                end else begin
                    if (rises < 9) bits_seen[8 - rises] = sd;
                    rises++;
                    if (rst_at >= 0 && rises == rst_at) begin
                        rst = 1'b1;
                        #1;
                        check("rst_scl", scl_o, 1);
                        check("rst_sda", sda_o, 1);
                        check("rst_ready", cmd_ready, 1);
                        check("rst_busy", busy, 0);
                        check("rst_done", done, 0);
                        m_busy  = 1'b0;
                        m_ack   = 1'b0;
                        m_rdata = 8'h00;
                        slave_sda = 1'b1;
                        @(negedge clk);
                        rst     = 1'b0;
                        aborted = 1;
                    end
                end
            end else if (!sl && prev_scl) begin
                if (rises < 8)       slave_sda = is_read ? sb[7 - rises] : 1'b1;
                else if (rises == 8) slave_sda = (c == 3'd2) ? sack : 1'b1;
                else                 slave_sda = 1'b1;
            end else if (sl && prev_scl && (sd !== prev_sda)) begin
                if (!sd) starts++;
                else     stops++;
            end
            if (done === 1'b1 && !aborted) begin
                got_done      = 1;
                done_cyc      = cyc;
                rdy_at_done   = cmd_ready;
                rdata_at_done = rdata;
                ack_at_done   = ack;
                busy_at_done  = busy;
            end
            prev_scl   = released ? 1'b0 : (scl_o & slave_scl);
            prev_sda   = sda_o & slave_sda;
            prev_scl_o = scl_o;
            prev_sda_o = sda_o;
        end

        if (aborted) begin
            got_done = 0;
            for (int k = 0; k < lat_exp; k++) begin
                @(negedge clk);
                if (done === 1'b1) got_done = 1;
            end
            check("no_done_after_reset", got_done, 0);
            check("busy_after_reset", busy, 0);
            check("rdata_after_reset", rdata, m_rdata);
            return;
        end

        check("done_seen", got_done, 1);
        check("latency", done_cyc, lat_exp);
        check("ready_at_done", rdy_at_done, 1);
        case (c)
            3'd0:       m_busy  = 1'b1;
            3'd1:       m_busy  = 1'b0;
            3'd2:       m_ack   = sack;
            3'd3, 3'd4: m_rdata = sb;
            default:    ;
        endcase
        check("busy", busy_at_done, m_busy);
        check("ack", ack_at_done, m_ack);
        check("rdata", rdata_at_done, m_rdata);
        if (is_byte) check("bus_bits", bits_seen, bits_exp);
        if (is_bus) begin
            check("start_cond", starts, (c == 3'd0) ? 1 : 0);
            check("stop_cond", stops, (c == 3'd1) ? 1 : 0);
        end
        if (c == 3'd0) check("start_q0_scl", first_scl_o, !busy_before);
        if (!is_bus) check("undef_toggles", toggles, 0);
        @(negedge clk);
        check("done_pulse_width", done, 0);
    endtask

    initial begin
        logic [7:0] rb;
        logic [2:0] rc;
        rst = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; wdata = 8'h00;
        slave_scl = 1'b1; slave_sda = 1'b1;
        m_busy = 1'b0; m_ack = 1'b0; m_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_scl", scl_o, 1);
        check("reset_sda", sda_o, 1);
        check("reset_ready", cmd_ready, 1);
        check("reset_done", done, 0);
        check("reset_rdata", rdata, 0);
        check("reset_ack", ack, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // Write 0xA6 with ACK
        run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd2, 8'hA6, 8'h00, 1'b0, -1, -1);
        run_cmd(3'd1, 8'h00, 8'h00, 1'b1, -1, -1);

        // Write then two reads
        run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd2, 8'h45, 8'h00, 1'b0, -1, -1);
        run_cmd(3'd3, 8'h00, 8'h3C, 1'b1, -1, -1);
        run_cmd(3'd4, 8'h00, 8'hF0, 1'b1, -1, -1);
        run_cmd(3'd1, 8'h00, 8'h00, 1'b1, -1, -1);

        // Repeated start, with a NAK on the write
        run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd2, 8'h44, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd1, 8'h00, 8'h00, 1'b1, -1, -1);

        // Clock stretching during bit 3
        run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd2, 8'($urandom), 8'h00, 1'b0, 3, -1);
        run_cmd(3'd1, 8'h00, 8'h00, 1'b1, -1, -1);

        // Undefined code while idle and while owning the bus
        run_cmd(3'd7, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd5, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd1, 8'h00, 8'h00, 1'b1, -1, -1);

        // Reset in the middle of a read (bit 5 rising edge)
        run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        run_cmd(3'd3, 8'h00, 8'h5A, 1'b1, -1, 6);

        // Randomised transactions
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            rc = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
            run_cmd(3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
            run_cmd(3'd2, 8'($urandom), 8'h00, 1'($urandom_range(0, 1)), -1, -1);
            run_cmd(rc, 8'h00, rb, 1'b1, -1, -1);
            run_cmd(3'd1, 8'h00, 8'h00, 1'b1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Synthesizable byte-level I2C master. It sits directly upstream of the I2C slave bus-functional interface, so it is what drives SCL/SDA on that bus.
- Accepts one command at a time: START, STOP, WRITE byte, READ byte with ACK, READ byte with NAK.
- Turns each command into open-drain SCL/SDA waveforms timed by a quarter-bit prescaler, and honours slave clock stretching.
- Returns a completion pulse, the read byte and the received ACK bit to the Wishbone-side register logic.

Parameters:
- CLK_DIV, 4, system clocks per quarter SCL bit period; legal values 2..65535.
- I2C_DATA_WIDTH, 8, bits per data byte on the bus.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  master can accept a command.
- cmd_i  in  3  command code, type i2c_cmd_t.
- wdata_i  in  I2C_DATA_WIDTH  byte to transmit; sampled at command acceptance.
- done_o  out  1  one-cycle pulse when a command completes.
- rdata_o  out  I2C_DATA_WIDTH  received byte; valid from done_o of a READ.
- ack_o  out  1  SDA sampled in the 9th bit of a WRITE; 0 = ACK.
- busy_o  out  1  bus owned: set by START completion, cleared by STOP completion.
- scl_i  in  1  resolved SCL line.
- scl_o  out  1  0 = pull SCL low, 1 = release.
- sda_i  in  1  resolved SDA line.
- sda_o  out  1  0 = pull SDA low, 1 = release.

Behaviour:
Reset:
- rst_i asserts outputs immediately: scl_o=1, sda_o=1, cmd_ready_o=1, done_o=0, rdata_o=0, ack_o=0, busy_o=0.
- FSM goes to IDLE; prescaler and bit counter go to 0.
- Reset mid-command abandons the command: no done_o, bus released at once.

Handshake:
- A command is accepted on a rising clk_i edge where cmd_valid_i && cmd_ready_o. cmd_ready_o drops the next cycle.
- done_o pulses for one cycle. cmd_ready_o is high again in that same cycle, so back-to-back commands leave no idle gap.

Prescaler:
- Counts 0..CLK_DIV-1; quarter tick at CLK_DIV-1, then wraps to 0.
- In phase Q1 (SCL released), the counter is held at 0 while scl_i==0. This is the clock-stretching wait and has unbounded length.

FSM states: IDLE, START, STOP, BIT, ACKBIT, DONE. Every bit is four quarters, Q0..Q3:
- START:
  - Q0: scl_o = busy_o ? 0 : 1; sda_o=1.
  - Q1: scl=1, sda=1.
  - Q2: scl=1, sda=0.
  - Q3: scl=0, sda=0.
  - Sets busy_o. If already busy, this is a repeated start.
- STOP:
  - Q0: scl=0, sda=0.
  - Q1: scl=1, sda=0.
  - Q2: scl=1, sda=1.
  - Q3: hold released.
  - Clears busy_o.
- Data bit:
  - Q0: scl=0, sda=bit.
  - Q1 and Q2: scl=1, sda=bit.
  - sda_i is sampled on the final tick of Q2.
  - Q3: scl=0, SDA held.
- WRITE:
  - Eight BIT phases driving wdata_i, MSB first.
  - ACKBIT phase with sda_o=1; ack_o is updated from the ACKBIT sample.
- READ_ACK / READ_NAK:
  - Eight BIT phases with sda_o=1, shifting sda_i in MSB first.
  - ACKBIT drives sda_o=0 for READ_ACK and 1 for READ_NAK.
  - rdata_o updates in the same cycle as done_o.
- DONE: one cycle, asserts done_o, returns to IDLE.

Latency, acceptance to done_o, with no stretching:
- START/STOP: 4*CLK_DIV+1 cycles.
- Byte commands: 36*CLK_DIV+1 cycles.

Boundary cases:
- Undefined cmd_i code: accepted, no bus activity, done_o after 1 cycle.
- WRITE/READ with busy_o=0: executed anyway, no error.
- ack_o and rdata_o hold their values across unrelated commands.

Decomposition:
- i2c_master_pkg holds:
  - enum i2c_cmd_t: CMD_START=0, CMD_STOP=1, CMD_WRITE=2, CMD_READ_ACK=3, CMD_READ_NAK=4.
  - the FSM state enum.
  - localparam QUARTERS_PER_BIT=4.
- One sub-module, i2c_quarter_timer: prescaler with stretch hold input, tick output and quarter index.

Test Plan:
- CLK_DIV=4; START, WRITE 0xA6 with slave ACK, STOP -> SDA bits 1,0,1,0,0,1,1,0 on SCL rising edges; ack_o=0; done_o at cycles 17, 145, 17 after each acceptance; busy_o 0→1→0.
- START, WRITE 0x45, READ_ACK with slave 0x3C, READ_NAK with slave 0xF0, STOP -> rdata_o=0x3C then 0xF0; master SDA low in first ACKBIT, released in second.
- Repeated start: START, WRITE 0x44, START -> second START drives SCL low in Q0, then SDA falls while SCL high; busy_o stays 1.
- Slave holds SCL low 50 cycles in Q1 of bit 3 of a WRITE -> done_o delayed by exactly 50 cycles; no bit lost.
- rst_i pulsed mid-READ at bit 5 -> scl_o=sda_o=1 and cmd_ready_o=1 in the same cycle; no done_o; busy_o=0.
- cmd_i=7 -> done_o 1 cycle after acceptance; scl_o/sda_o never toggle.
